// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared constants and helpers for the async_fifo block.
//  - ptr_width(): pointer width for a given depth (address bits plus one
//    wrap bit that lets full and empty be told apart).
//  - PTR_RST / DOUT_RST: reset values for the pointers and the read data,
//    replicated to the required width at the point of use.
package async_fifo_pkg;

  localparam logic PTR_RST  = 1'b0;
  localparam logic DOUT_RST = 1'b0;

  // Pointer width: clog2(depth) address bits plus the wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// async_fifo_mem: D x W dual-port register array with a registered read port.
// Ports:
//  clk    in  1   clock
//  rst    in  1   synchronous active-high reset (clears rdata only)
//  we     in  1   write enable
//  waddr  in  AW  write address
//  wdata  in  W   write data
//  re     in  1   read enable
//  raddr  in  AW  read address
//  rdata  out W   registered read data, holds when re is low
module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int W  = 8,
  parameter int D  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [D];
  logic [W-1:0] rdata_r;

  // Storage array write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; the output keeps its last value when no read occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {W{DOUT_RST}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock W x D FIFO with registered read data and
// combinational full/empty flags derived from the registered pointers.
// Optional feature macro: ASYNC_FIFO_COUNT_EN adds a registered occupancy
// output 'count'.
// Ports:
//  w_clk  in  1     the only clock (read and write)
//  w_rst  in  1     synchronous active-high reset
//  w_en   in  1     write request (accepted when not full)
//  r_en   in  1     read request (accepted when not empty)
//  d_in   in  W     write data
//  d_out  out W     read data, registered, holds when no read is accepted
//  full   out 1     no free entry
//  empty  out 1     no stored entry
//  count  out AW+1  occupancy 0..D (ASYNC_FIFO_COUNT_EN only)
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int D  = 32,
  localparam int PW = ptr_width(D),
  localparam int AW = PW - 1
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic         w_en,
  input  logic         r_en,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out,
  output logic         full,
  output logic         empty
`ifdef ASYNC_FIFO_COUNT_EN
  ,
  output logic [AW:0]  count
`endif
);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        full_s;
  logic        empty_s;
  logic        wr_acc_s;
  logic        rd_acc_s;

  // Pointers match exactly when empty; full when only the wrap bit differs.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // Blocked requests are simply not accepted; requests during reset are ignored.
  assign wr_acc_s = w_en && !full_s  && !w_rst;
  assign rd_acc_s = r_en && !empty_s && !w_rst;

  // Write pointer: advances on every accepted write, wraps modulo 2*D.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wr_ptr_r <= {PW{PTR_RST}};
    end else if (wr_acc_s) begin
      wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer: advances on every accepted read, wraps modulo 2*D.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      rd_ptr_r <= {PW{PTR_RST}};
    end else if (rd_acc_s) begin
      rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  async_fifo_mem #(
    .W  (W),
    .D  (D),
    .AW (AW)
  ) u_mem (
    .clk   (w_clk),
    .rst   (w_rst),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r[AW-1:0]),
    .wdata (d_in),
    .re    (rd_acc_s),
    .raddr (rd_ptr_r[AW-1:0]),
    .rdata (d_out)
  );

  assign full  = full_s;
  assign empty = empty_s;

`ifdef ASYNC_FIFO_COUNT_EN
  logic [AW:0] count_r;

  // Occupancy counter; tracks wr_ptr - rd_ptr, unchanged on read+write.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      count_r <= {PW{PTR_RST}};
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed scoreboard bench for async_fifo (W=8, D=32).
// Stimulus pushes the expected read data into exp_q when a read will be
// accepted; a separate monitor pops and compares d_out after that edge.
module tb_async_fifo;

  logic       w_clk;
  logic       w_rst;
  logic       w_en;
  logic       r_en;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       full;
  logic       empty;
`ifdef ASYNC_FIFO_COUNT_EN
  logic [5:0] count;
`endif

  async_fifo #(.W(8), .D(32)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_en  (w_en),
    .r_en  (r_en),
    .d_in  (d_in),
    .d_out (d_out),
    .full  (full),
`ifdef ASYNC_FIFO_COUNT_EN
    .count (count),
`endif
    .empty (empty)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  int         rd_issued;
  int         rd_checked;
  int         n_checks;
  int         n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_count(input string nm, input int exp);
`ifdef ASYNC_FIFO_COUNT_EN
    chk(nm, 32'(count), 32'(exp));
`else
    chk(nm, 32'(model.size()), 32'(exp));
`endif
  endtask

  // Monitor: compares every accepted read against the scoreboard.
  always @(negedge w_clk) begin
    while (rd_checked < rd_issued) begin
      rd_checked++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL d_out_seq: got %0d expected <none queued>", d_out);
      end else begin
        chk("d_out_seq", 32'(d_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock cycle of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic acc_w;
    logic acc_r;
    @(negedge w_clk);
    w_en = w;
    r_en = r;
    d_in = d;
    acc_r = r && (model.size() != 0);
    acc_w = w && (model.size() < 32);
    @(posedge w_clk);
    if (acc_r) begin
      exp_q.push_back(model.pop_front());
      rd_issued++;
    end
    if (acc_w) model.push_back(d);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    #1;
    w_rst = 1'b1;
    w_en  = 1'b1;
    r_en  = 1'b1;
    d_in  = 8'hAA;
    @(posedge w_clk);
    @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    w_en  = 1'b0;
    r_en  = 1'b0;
    model.delete();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rd_issued  = 0;
    rd_checked = 0;
    w_rst = 1'b0;
    w_en  = 1'b0;
    r_en  = 1'b0;
    d_in  = 8'h00;

    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(d_out), 32'd0);
    chk_count("rst_count", 0);
    cycle(1'b0, 1'b1, 8'h00);
    chk("rd_empty_dout", 32'(d_out), 32'd0);
    chk("rd_empty_flag", 32'(empty), 32'd1);

    // Write 0..19, then read 10
    cycle(1'b1, 1'b0, 8'd0);
    chk("first_wr_empty", 32'(empty), 32'd0);
    for (int i = 1; i < 20; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("after10_dout", 32'(d_out), 32'd9);
    chk("after10_empty", 32'(empty), 32'd0);
    chk_count("after10_count", 10);

    // Write 20..34, read all 25
    for (int i = 20; i < 35; i++) cycle(1'b1, 1'b0, 8'(i));
    chk_count("count25", 25);
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_dout", 32'(d_out), 32'd34);

    // Reads while empty are ignored
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("hold_dout", 32'(d_out), 32'd34);
    chk("hold_empty", 32'(empty), 32'd1);
    chk("hold_full", 32'(full), 32'd0);
    chk_count("hold_count", 0);

    // Fill with 100..131, overflow write of 200 is dropped
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 1'b0, 8'(100 + i));
      if (i == 30) chk("full_at31", 32'(full), 32'd0);
    end
    chk("full_at32", 32'(full), 32'd1);
    chk_count("count32", 32);
    cycle(1'b1, 1'b0, 8'd200);
    chk("full_after_drop", 32'(full), 32'd1);
    chk_count("count_after_drop", 32);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("fill_drain_empty", 32'(empty), 32'd1);
    chk("fill_drain_dout", 32'(d_out), 32'd131);

    // At full, read+write: read accepted, write dropped
    for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 8'(150 + i));
    chk("full_again", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 8'd99);
    chk("rw_full_full", 32'(full), 32'd0);
    chk("rw_full_dout", 32'(d_out), 32'd150);
    chk_count("rw_full_count", 31);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 8'h00);
    chk_count("one_left_count", 1);

    // At one entry, read+write together across the address wrap
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 8'(i + 1));
    chk_count("rw_one_count", 1);
    chk("rw_one_empty", 32'(empty), 32'd0);
    chk("rw_one_dout", 32'(d_out), 32'd39);
    cycle(1'b0, 1'b1, 8'h00);
    chk("rw_one_last", 32'(d_out), 32'd40);
    chk("rw_one_drained", 32'(empty), 32'd1);

    // Mid-operation reset discards stored data
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(60 + i));
    cycle(1'b0, 1'b1, 8'h00);
    do_reset();
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_full", 32'(full), 32'd0);
    chk("midrst_dout", 32'(d_out), 32'd0);
    chk_count("midrst_count", 0);
    cycle(1'b1, 1'b0, 8'd55);
    cycle(1'b0, 1'b1, 8'h00);
    chk("post_rst_dout", 32'(d_out), 32'd55);

    @(negedge w_clk);
    @(negedge w_clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("monitor_caught_up", 32'(rd_checked), 32'(rd_issued));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
